dram_arbiter: RTL and testbench



---
 rtl/dram_arb_pkg.sv | 7 +
 rtl/dram_arb_grant.sv | 30 +++
 rtl/dram_arbiter.sv | 107 ++++++++++
 tb/tb_dram_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared constants and FSM state type for the two-client DRAM arbiter
package dram_arb_pkg;
  localparam int DRAM_DEPTH = 8192;
  localparam int DATA_W = 64;
  localparam int REQ_ADDR_W = $clog2(DRAM_DEPTH);
  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, RSP} state_t;
endpackage

// File: rtl/dram_arb_grant.sv
// dram_arb_grant: picks one of two pending clients when en_i is high.
//   valid_i    : per-client request pending
//   en_i       : arbiter is able to accept a request this cycle
//   grant_o    : one-hot grant (zero when disabled or nothing pending)
//   grant_id_o : index of the client that wins
//   Build option DRAM_ARB_RR_EN: round-robin with a pointer register (clk/rst_n
//   ports exist only then); otherwise client 0 has fixed priority.
module dram_arb_grant (
`ifdef DRAM_ARB_RR_EN
  input  logic       clk,
  input  logic       rst_n,
`endif
  input  logic [1:0] valid_i,
  input  logic       en_i,
  output logic [1:0] grant_o,
  output logic       grant_id_o
);
`ifdef DRAM_ARB_RR_EN
  logic ptr_q, ptr_d;
  // ptr_q names the client that wins the next tie; it flips to the loser after each grant
  assign grant_id_o = &valid_i ? ptr_q : valid_i[1];
  assign ptr_d = (en_i && |valid_i) ? ~grant_id_o : ptr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
`else
  assign grant_id_o = ~valid_i[0];
`endif
  assign grant_o = en_i ? (valid_i & (grant_id_o ? 2'b10 : 2'b01)) : 2'b00;
endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: serialises requests from two clients onto an AXI-like DRAM port.
//   clk, rst_n           : single clock, asynchronous active-low reset
//   req_*                : per-client request (valid/write/addr/wdata) and ready pulse
//   rsp_valid/id/data    : one-cycle completion pulse, read data (0 for writes)
//   AR/R/AW/W/B channels : DRAM side, one transaction in flight at a time
//   Build option DRAM_ARB_RR_EN selects round-robin arbitration (default: client 0 priority).
module dram_arbiter #(
  parameter int DATA_W     = dram_arb_pkg::DATA_W,
  parameter int REQ_ADDR_W = dram_arb_pkg::REQ_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 req_valid,
  input  logic [1:0]                 req_write,
  input  logic [1:0][REQ_ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0]     req_wdata,
  output logic [1:0]                 req_ready,
  output logic                       rsp_valid,
  output logic                       rsp_id,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       AR_VALID,
  output logic [31:0]                AR_ADDR,
  input  logic                       AR_READY,
  input  logic                       R_VALID,
  input  logic [DATA_W-1:0]          R_DATA,
  input  logic [1:0]                 R_RESP,
  output logic                       R_READY,
  output logic                       AW_VALID,
  output logic [31:0]                AW_ADDR,
  input  logic                       AW_READY,
  output logic                       W_VALID,
  output logic [DATA_W-1:0]          W_DATA,
  input  logic                       W_READY,
  input  logic                       B_VALID,
  input  logic [1:0]                 B_RESP,
  output logic                       B_READY
);
  import dram_arb_pkg::*;
  state_t state_q, state_d;
  logic [REQ_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic write_q, write_d, id_q, id_d;
  logic [1:0] grant;
  logic grant_id, idle;
  logic unused_resp;
  assign unused_resp = ^{R_RESP, B_RESP};
  // gating with rst_n keeps req_ready low while reset is held even though IDLE is the reset state
  assign idle = rst_n && state_q == IDLE;
  dram_arb_grant u_grant (
`ifdef DRAM_ARB_RR_EN
    .clk        (clk),
    .rst_n      (rst_n),
`endif
    .valid_i    (req_valid),
    .en_i       (idle),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      write_q <= write_d;
      id_q    <= id_d;
    end
  // data_q holds write data for writes and is reused to capture read data
  always_comb begin
    addr_d  = |grant ? req_addr[grant_id] : addr_q;
    write_d = |grant ? req_write[grant_id] : write_q;
    id_d    = |grant ? grant_id : id_q;
    data_d  = |grant ? req_wdata[grant_id] : (state_q == R && R_VALID) ? R_DATA : data_q;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = |grant ? (req_write[grant_id] ? AW : AR) : IDLE;
      AR:      state_d = AR_READY ? R : AR;
      R:       state_d = R_VALID ? RSP : R;
      AW:      state_d = AW_READY ? W : AW;
      W:       state_d = W_READY ? B : W;
      B:       state_d = B_VALID ? RSP : B;
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    req_ready = grant;
    AR_VALID  = state_q == AR;
    AR_ADDR   = AR_VALID ? 32'(addr_q) : 32'd0;
    R_READY   = state_q == R;
    AW_VALID  = state_q == AW;
    AW_ADDR   = AW_VALID ? 32'(addr_q) : 32'd0;
    W_VALID   = state_q == W;
    W_DATA    = W_VALID ? data_q : '0;
    B_READY   = state_q == B;
    rsp_valid = state_q == RSP;
    rsp_id    = rsp_valid & id_q;
    rsp_data  = (rsp_valid && !write_q) ? data_q : '0;
  end
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: randomized and directed checks of dram_arbiter against a pseudo DRAM and a transaction-level model
module tb_dram_arbiter;
`ifdef DRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic cv[2], cw[2];
  logic [12:0] ca[2];
  logic [63:0] cd[2];
  logic [1:0] req_valid, req_write, req_ready;
  logic [1:0][12:0] req_addr;
  logic [1:0][63:0] req_wdata;
  assign req_valid = {cv[1], cv[0]};
  assign req_write = {cw[1], cw[0]};
  assign req_addr  = {ca[1], ca[0]};
  assign req_wdata = {cd[1], cd[0]};
  logic rsp_valid, rsp_id;
  logic [63:0] rsp_data;
  logic AR_VALID = 0, AR_READY = 0, R_VALID = 0, R_READY, AW_VALID, AW_READY = 0;
  logic W_VALID, W_READY = 0, B_VALID = 0, B_READY;
  logic [31:0] AR_ADDR, AW_ADDR;
  logic [63:0] R_DATA = 0, W_DATA;
  logic [1:0] R_RESP = 0, B_RESP = 0;

  dram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
    .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
  );

  int n_chk = 0, n_pass = 0;
  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", nm, got, exp, $time);
  endfunction
  function automatic void timeout_fail(input string nm);
    n_chk++;
    $display("FAIL %s: bound expired at t=%0t", nm, $time);
  endfunction
  function automatic logic [63:0] pat(input logic [12:0] a);
    return 64'h0123_4567_0000_0000 | (64'(a) * 64'd3);
  endfunction

  // pseudo DRAM: each channel accepts after a configurable (or random) number of wait cycles
  logic [63:0] dram [8192];
  int cfg_ar = 0, cfg_r = 0, cfg_aw = 0, cfg_w = 0, cfg_b = 0;
  bit rand_mode = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [12:0] rd_addr = 0, wr_addr = 0;
  task automatic step(input logic v, inout int cnt, inout int dly, input int cfg, output logic rdy);
    if (!v) begin
      cnt = 0;
      rdy = 1'b0;
    end else begin
      if (cnt == 0) dly = rand_mode ? int'($urandom_range(0, 4)) : cfg;
      rdy = cnt >= dly;
      cnt++;
    end
  endtask
  initial begin
    logic s_arv, s_arr, s_awv, s_awr, s_wv, s_wr;
    logic [12:0] s_ara, s_awa;
    logic [63:0] s_wd;
    for (int i = 0; i < 8192; i++) dram[i] = pat(13'(i));
    forever begin
      @(negedge clk);
      s_arv = AR_VALID; s_arr = AR_READY; s_ara = AR_ADDR[12:0];
      s_awv = AW_VALID; s_awr = AW_READY; s_awa = AW_ADDR[12:0];
      s_wv = W_VALID; s_wr = W_READY; s_wd = W_DATA;
      @(posedge clk);
      #2;
      if (s_arv && s_arr) rd_addr = s_ara;
      if (s_awv && s_awr) wr_addr = s_awa;
      if (s_wv && s_wr) dram[wr_addr] = s_wd;
      step(AR_VALID, ar_cnt, ar_dly, cfg_ar, AR_READY);
      step(R_READY, r_cnt, r_dly, cfg_r, R_VALID);
      step(AW_VALID, aw_cnt, aw_dly, cfg_aw, AW_READY);
      step(W_VALID, w_cnt, w_dly, cfg_w, W_READY);
      step(B_READY, b_cnt, b_dly, cfg_b, B_VALID);
      R_DATA = R_VALID ? dram[rd_addr] : {$urandom, $urandom};
      R_RESP = 2'($urandom);
      B_RESP = 2'($urandom);
    end
  end

  // transaction-level model: who should win, what is in flight, what the response must be
  bit busy = 0, pref = 0, exp_w = 0, exp_id = 0;
  logic [12:0] exp_a = 0;
  logic [63:0] exp_d = 0;
  logic [63:0] mm [logic [12:0]];
  logic [31:0] last_ar = 0;
  logic p_gnt = 0, p_arv = 0, p_arr = 0, p_rr = 0, p_rv = 0, p_awv = 0, p_awr = 0;
  logic p_wv = 0, p_wr = 0, p_br = 0, p_bv = 0;
  initial forever begin
    logic [1:0] eg;
    logic [63:0] er;
    @(negedge clk);
    if (!rst_n) begin
      chk("reset_outputs", 64'(|{req_ready, rsp_valid, rsp_id, rsp_data, AR_VALID, AR_ADDR, R_READY,
                                 AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY}), 64'd0);
      busy = 0; pref = 0;
      {p_gnt, p_arv, p_arr, p_rr, p_rv, p_awv, p_awr, p_wv, p_wr, p_br, p_bv} = '0;
    end else begin
      eg = (req_valid == 2'b11) ? (pref ? 2'b10 : 2'b01) : req_valid;
      chk("grant", req_ready, busy ? 2'b00 : eg);
      chk("chan_legal", 64'(((AR_VALID | R_READY) & ~(busy & ~exp_w)) | ((AW_VALID | W_VALID | B_READY) & ~(busy & exp_w))), 64'd0);
      if (p_gnt) chk("first_valid", {AR_VALID, AW_VALID}, exp_w ? 2'b01 : 2'b10);
      chk("ar_addr", AR_ADDR, AR_VALID ? 32'(exp_a) : 32'd0);
      chk("aw_addr", AW_ADDR, AW_VALID ? 32'(exp_a) : 32'd0);
      chk("w_data", W_DATA, W_VALID ? exp_d : 64'd0);
      if (p_arv && !p_arr) chk("ar_hold", AR_VALID, 1'b1);
      if (p_awv && !p_awr) chk("aw_hold", AW_VALID, 1'b1);
      if (p_wv && !p_wr) chk("w_hold", W_VALID, 1'b1);
      if (p_rr && !p_rv) chk("r_hold", R_READY, 1'b1);
      if (p_br && !p_bv) chk("b_hold", B_READY, 1'b1);
      if (p_arv && p_arr) chk("r_after_ar", {AR_VALID, R_READY}, 2'b01);
      if (p_awv && p_awr) chk("w_after_aw", {AW_VALID, W_VALID}, 2'b01);
      if (p_wv && p_wr) chk("b_after_w", {W_VALID, B_READY}, 2'b01);
      chk("r_excl", R_READY & (AR_VALID | AR_READY), 1'b0);
      chk("w_excl", W_VALID & (AW_VALID | AW_READY), 1'b0);
      chk("rsp_timing", rsp_valid, (p_rr & p_rv) | (p_br & p_bv));
      if (rsp_valid) begin
        er = exp_w ? 64'd0 : (mm.exists(exp_a) ? mm[exp_a] : pat(exp_a));
        chk("rsp_id", rsp_id, exp_id);
        chk("rsp_data", rsp_data, er);
        if (exp_w) mm[exp_a] = exp_d;
        busy = 0;
      end
      if (AR_VALID) last_ar = AR_ADDR;
      p_gnt = |(req_ready & req_valid);
      if (p_gnt) begin
        exp_id = req_ready[1];
        exp_w = req_write[exp_id];
        exp_a = req_addr[exp_id];
        exp_d = req_wdata[exp_id];
        busy = 1;
        pref = RR ? ~exp_id : 1'b0;
      end
      p_arv = AR_VALID; p_arr = AR_READY; p_rr = R_READY; p_rv = R_VALID;
      p_awv = AW_VALID; p_awr = AW_READY; p_wv = W_VALID; p_wr = W_READY;
      p_br = B_READY; p_bv = B_VALID;
    end
  end

  logic rid;
  logic [63:0] rdat;
  task automatic client_txn(input int id, input logic w, input logic [12:0] a, input logic [63:0] d, output int gc);
    int n = 0;
    @(posedge clk);
    #1;
    cv[id] = 1'b1; cw[id] = w; ca[id] = a; cd[id] = d;
    gc = -1;
    while (gc < 0 && n < 3000) begin
      @(negedge clk);
      if (req_ready[id]) gc = cyc;
      n++;
    end
    if (gc < 0) timeout_fail("grant_wait");
    @(posedge clk);
    #1;
    cv[id] = 1'b0;
  endtask
  task automatic wait_rsp(output int rc);
    int n = 0;
    rc = -1;
    while (rc < 0 && n < 3000) begin
      @(negedge clk);
      if (rsp_valid) begin
        rc = cyc; rid = rsp_id; rdat = rsp_data;
      end
      n++;
    end
    if (rc < 0) timeout_fail("rsp_wait");
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy) timeout_fail("idle_wait");
  endtask
  task automatic rand_client(input int id);
    int g;
    repeat (100) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      client_txn(id, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 13'h1FFF : 13'($urandom_range(0, 15)),
                 {$urandom, $urandom}, g);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g, rc, n, k;
    int gs[4];
    for (int i = 0; i < 2; i++) begin
      cv[i] = 0; cw[i] = 0; ca[i] = 0; cd[i] = 0;
    end
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    // client 0 read of address 5 with 3 AR wait cycles and 10 R wait cycles
    cfg_ar = 3; cfg_r = 10;
    client_txn(0, 1'b0, 13'd5, 64'd0, g);
    wait_rsp(rc);
    chk("rd_latency", 64'(rc - g), 64'd16);
    chk("rd_rsp_id", rid, 1'b0);
    chk("rd_rsp_data", rdat, 64'h0123_4567_0000_000F);
    chk("rd_ar_addr", last_ar, 32'd5);
    @(negedge clk);
    chk("rsp_one_cycle", rsp_valid, 1'b0);
    // client 1 write to the top address
    cfg_ar = 0; cfg_r = 0; cfg_aw = 2; cfg_w = 1; cfg_b = 2;
    client_txn(1, 1'b1, 13'h1FFF, 64'hDEADBEEF_CAFEF00D, g);
    wait_rsp(rc);
    chk("wr_latency", 64'(rc - g), 64'd9);
    chk("wr_rsp_id", rid, 1'b1);
    chk("wr_rsp_data", rdat, 64'd0);
    chk("wr_dram", dram[8191], 64'hDEADBEEF_CAFEF00D);
    // reset while the write data phase is stalled
    cfg_aw = 0; cfg_b = 0; cfg_w = 50;
    client_txn(0, 1'b1, 13'd100, 64'h1111_2222_3333_4444, g);
    n = 0;
    while (!W_VALID && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!W_VALID) timeout_fail("w_phase_wait");
    @(posedge clk);
    #3 rst_n = 1'b0;
    cfg_w = 0;
    #1;
    chk("async_w_valid", W_VALID, 1'b0);
    chk("async_all_zero", 64'(|{req_ready, rsp_valid, rsp_id, rsp_data, AR_VALID, AR_ADDR, R_READY,
                                AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY}), 64'd0);
    cv[0] = 1; cw[0] = 0; ca[0] = 13'd1;
    cv[1] = 1; cw[1] = 0; ca[1] = 13'd2;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    // both clients request continuously
    k = 0; n = 0;
    while (k < 4 && n < 500) begin
      @(negedge clk);
      if (|req_ready) begin
        gs[k] = int'(req_ready[1]);
        k++;
      end
      n++;
    end
    if (k < 4) timeout_fail("tie_grants");
    for (int i = 0; i < k; i++) chk($sformatf("tie_grant_%0d", i), 64'(gs[i]), RR ? 64'(i % 2) : 64'd0);
    @(posedge clk);
    #1;
    cv[0] = 0; cv[1] = 0;
    wait_idle();
    // random mixed traffic with random DRAM stalls
    rand_mode = 1;
    fork
      rand_client(0);
      rand_client(1);
    join
    wait_idle();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
